// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifq_pkg
// Description : Shared widths, constants, queue entry type and PC helper
//               for the instruction-fetch queue slice.
// Revision    : 1.0 - initial release
// ============================================================================
package ifq_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0]   PC_STEP = 32'd4;
  localparam logic [INST_W-1:0] NOP     = 32'h0000_0000;

  // One prefetch-queue slot: the fetch address travels with its word.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

  // Instruction fetch is word-granular; low address bits are discarded.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifq_fifo
// Description : Synchronous first-in first-out buffer with flush.
//               Push and pop may occur in the same cycle; flush has priority
//               over both. Pop when empty is ignored; push when full is only
//               taken if a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, reset  - clock, synchronous active-high reset
//               push, din    - write request and data
//               pop          - read acknowledge (advances the head)
//               flush        - discard all contents
//               dout         - head entry (undefined value when empty)
//               count        - occupancy, 0..DEPTH
//               full, empty  - occupancy flags
// ============================================================================
module ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        // DEPTH is a power of two, so the pointers wrap naturally.
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read from a slot before it is written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction-fetch front end. Owns the fetch PC, issues word
//               reads to a variable-latency instruction memory, buffers the
//               returned words with their PC in an in-order prefetch queue
//               and presents them to the core over valid/ready. A redirect
//               flushes the queue and arranges for every response still in
//               flight to be discarded on arrival.
// Revision    : 1.0 - initial release
// Config      : IFQ_BYPASS_EN - when defined, a non-dropped response that
//               arrives while the queue is empty is presented to the core in
//               the same cycle (and not enqueued if consumed). When undefined
//               every response is enqueued and appears one cycle later.
// Parameters  : DEPTH    - queue entries and cap on outstanding + queued
//                          fetches (power of two, >= 2)
//               RESET_PC - fetch PC after reset
// Ports       : clk, reset          - clock, synchronous active-high reset
//               imem_req_valid/ready/addr - fetch request channel
//               imem_resp_valid/data      - in-order fetch responses
//               redirect_valid/pc         - new fetch stream from the core
//               inst_valid/ready          - handshake toward the core
//               inst_data, inst_pc, inst_pc_plus4 - head instruction
// ============================================================================
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] fetch_pc_q,    fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q,        drop_d;

  // --------------------------------------------------------------------------
  // Sub-block wiring
  // --------------------------------------------------------------------------
  ifq_entry_t      q_din;
  ifq_entry_t      q_head;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;

  logic [PC_W-1:0] a_head;
  logic [CW-1:0]   a_count;
  logic            a_full;
  logic            a_empty;

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            resp_keep;
  logic            bypass;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  // Every accepted request already owns a queue slot, so a response can
  // always be stored. Extra bit keeps the sum from wrapping.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, q_count};
  assign imem_req_valid = !reset && !redirect_valid
                          && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // --------------------------------------------------------------------------
  // Response side
  // --------------------------------------------------------------------------
  assign resp_keep = imem_resp_valid && (drop_q == '0);

`ifdef IFQ_BYPASS_EN
  // Only an empty queue can hand a fresh response straight to the core;
  // otherwise the queue head owns the output this cycle.
  assign bypass = resp_keep && !redirect_valid && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign q_din.pc   = a_head;
  assign q_din.inst = imem_resp_data;
  assign q_push     = resp_keep && !(bypass && inst_ready);
  assign q_pop      = !q_empty && inst_ready;

  // --------------------------------------------------------------------------
  // Output to core
  // --------------------------------------------------------------------------
  always_comb begin
    inst_valid    = 1'b0;
    inst_data     = NOP;
    inst_pc       = '0;
    inst_pc_plus4 = '0;
    if (!q_empty) begin
      inst_valid    = 1'b1;
      inst_data     = q_head.inst;
      inst_pc       = q_head.pc;
      inst_pc_plus4 = q_head.pc + PC_STEP;
    end else if (bypass) begin
      inst_valid    = 1'b1;
      inst_data     = imem_resp_data;
      inst_pc       = a_head;
      inst_pc_plus4 = a_head + PC_STEP;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_d        = drop_q;

    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      // No request fires during a redirect, so everything still in flight
      // after this cycle's response belongs to the abandoned stream.
      drop_d     = outstanding_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= align_pc(RESET_PC);
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction queue: {pc, inst} entries, flushed by redirect.
  // --------------------------------------------------------------------------
  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(ifq_entry_t))
  ) u_inst_q (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // --------------------------------------------------------------------------
  // Pending-address FIFO: one PC per accepted request. Never flushed, so the
  // addresses of stale responses drain in step with the responses.
  // --------------------------------------------------------------------------
  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W)
  ) u_addr_q (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (imem_resp_valid),
    .flush (1'b0),
    .din   (fetch_pc_q),
    .dout  (a_head),
    .count (a_count),
    .full  (a_full),
    .empty (a_empty)
  );

  // --------------------------------------------------------------------------
  // Protocol and invariant checks
  // --------------------------------------------------------------------------
  a_resp_without_request: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (outstanding_q != '0) && !a_empty);

  a_queue_full_on_push: assert property (@(posedge clk) disable iff (reset)
    (q_push && !redirect_valid) |-> !q_full);

  a_addr_overflow: assert property (@(posedge clk) disable iff (reset)
    req_fire |-> !a_full);

  a_addr_tracks_outstanding: assert property (@(posedge clk) disable iff (reset)
    a_count == outstanding_q);

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Directed bench for ifetch_queue. A memory model returns
//               addr + 32'h1000 after a programmable latency; delivered
//               instructions are logged and compared with hand-derived
//               sequences. A second instance with RESET_PC = 32'hFFFF_FFF8
//               and a fixed 1-cycle memory covers address wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        reset          = 1'b1;
  logic        req_ready      = 1'b1;
  logic        resp_valid     = 1'b0;
  logic [31:0] resp_data      = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_ready     = 1'b1;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  // Wrap-around instance
  logic        b_req_ready      = 1'b1;
  logic        b_resp_valid     = 1'b0;
  logic [31:0] b_resp_data      = '0;
  logic        b_redirect_valid = 1'b0;
  logic [31:0] b_redirect_pc    = '0;
  logic        b_inst_ready     = 1'b1;
  logic        b_req_valid;
  logic [31:0] b_req_addr;
  logic        b_inst_valid;
  logic [31:0] b_inst_data;
  logic [31:0] b_inst_pc;
  logic [31:0] b_inst_pc_plus4;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (req_valid),
    .imem_req_ready  (req_ready),
    .imem_req_addr   (req_addr),
    .imem_resp_valid (resp_valid),
    .imem_resp_data  (resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4)
  );

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (b_req_valid),
    .imem_req_ready  (b_req_ready),
    .imem_req_addr   (b_req_addr),
    .imem_resp_valid (b_resp_valid),
    .imem_resp_data  (b_resp_data),
    .redirect_valid  (b_redirect_valid),
    .redirect_pc     (b_redirect_pc),
    .inst_valid      (b_inst_valid),
    .inst_ready      (b_inst_ready),
    .inst_data       (b_inst_data),
    .inst_pc         (b_inst_pc),
    .inst_pc_plus4   (b_inst_pc_plus4)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int lat   = 1;
  int cyc   = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          hs_cnt   = 0;
  int          first_hs = -1;
  int          first_dl = -1;
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  logic [31:0] got_p4[$];
  logic [31:0] got_cyc[$];

  logic        b_hs_rec   = 1'b0;
  logic [31:0] b_addr_rec = '0;
  logic [31:0] b_got_pc[$];
  logic [31:0] b_got_p4[$];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // Sample mid-cycle, then drive memory responses just after the next edge.
  always begin
    @(negedge clk);
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      got_pc.delete();
      got_data.delete();
      got_p4.delete();
      got_cyc.delete();
      b_got_pc.delete();
      b_got_p4.delete();
      hs_cnt   = 0;
      first_hs = -1;
      first_dl = -1;
      b_hs_rec = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        pend_addr.push_back(req_addr);
        pend_due.push_back(cyc + lat);
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        got_pc.push_back(inst_pc);
        got_data.push_back(inst_data);
        got_p4.push_back(inst_pc_plus4);
        got_cyc.push_back(32'(cyc));
        if (first_dl < 0) first_dl = cyc;
      end
      b_hs_rec   = b_req_valid && b_req_ready;
      b_addr_rec = b_req_addr;
      if (b_inst_valid && b_inst_ready) begin
        b_got_pc.push_back(b_inst_pc);
        b_got_p4.push_back(b_inst_pc_plus4);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    resp_valid = 1'b0;
    resp_data  = '0;
    if (!reset && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = pend_addr[0] + 32'h1000;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    b_resp_valid = b_hs_rec;
    b_resp_data  = b_addr_rec + 32'h1000;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns 2 ns after the first edge following release (request cycle r).
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // ---- reset state ----
    step(2);
    @(negedge clk);
    check_vec("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_vec("rst_req_valid", 32'(req_valid), 32'd0);
    check_vec("rst_inst_data", inst_data, 32'h0);
    check_vec("rst_inst_pc", inst_pc, 32'h0);
    check_vec("rst_pc_plus4", inst_pc_plus4, 32'h0);

    // ---- streaming, 1-cycle memory ----
    lat = 1;
    inst_ready = 1'b1;
    step(1);
    do_reset();
    @(negedge clk);
    check_vec("first_req_valid", 32'(req_valid), 32'd1);
    check_vec("first_req_addr", req_addr, 32'h0);
    step(12);
    check_vec("s_pc0", at(got_pc, 0), 32'h0);
    check_vec("s_pc1", at(got_pc, 1), 32'h4);
    check_vec("s_pc2", at(got_pc, 2), 32'h8);
    check_vec("s_pc3", at(got_pc, 3), 32'hC);
    check_vec("s_data0", at(got_data, 0), 32'h1000);
    check_vec("s_data3", at(got_data, 3), 32'h100C);
    check_vec("s_plus4_2", at(got_p4, 2), 32'hC);
    check_vec("s_latency", 32'(first_dl - first_hs), 32'(EXP_LAT));
    check_vec("s_throughput", at(got_cyc, 3) - at(got_cyc, 0), 32'd3);
    check_vec("wrap_pc0", at(b_got_pc, 0), 32'hFFFF_FFF8);
    check_vec("wrap_pc1", at(b_got_pc, 1), 32'hFFFF_FFFC);
    check_vec("wrap_pc2", at(b_got_pc, 2), 32'h0000_0000);
    check_vec("wrap_plus4_0", at(b_got_p4, 0), 32'hFFFF_FFFC);
    check_vec("wrap_plus4_1", at(b_got_p4, 1), 32'h0000_0000);

    // ---- back-pressure ----
    lat = 1;
    inst_ready = 1'b0;
    do_reset();
    step(20);
    @(negedge clk);
    check_vec("bp_req_count", 32'(hs_cnt), 32'd4);
    check_vec("bp_req_valid", 32'(req_valid), 32'd0);
    check_vec("bp_inst_valid", 32'(inst_valid), 32'd1);
    check_vec("bp_head_pc", inst_pc, 32'h0);
    check_vec("bp_head_data", inst_data, 32'h1000);
    step(1);
    inst_ready = 1'b1;
    step(10);
    check_vec("bp_pc0", at(got_pc, 0), 32'h0);
    check_vec("bp_pc1", at(got_pc, 1), 32'h4);
    check_vec("bp_pc2", at(got_pc, 2), 32'h8);
    check_vec("bp_pc3", at(got_pc, 3), 32'hC);
    check_vec("bp_pc4", at(got_pc, 4), 32'h10);
    check_vec("bp_data3", at(got_data, 3), 32'h100C);

    // ---- redirect with three fetches in flight, 3-cycle memory ----
    lat = 3;
    inst_ready = 1'b1;
    do_reset();
    step(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step(1);
    redirect_valid = 1'b0;
    step(14);
    check_vec("rd_pc0", at(got_pc, 0), 32'h0000_0100);
    check_vec("rd_pc1", at(got_pc, 1), 32'h0000_0104);
    check_vec("rd_data0", at(got_data, 0), 32'h0000_1100);
    check_vec("rd_data1", at(got_data, 1), 32'h0000_1104);

    // ---- back-to-back redirects ----
    lat = 3;
    do_reset();
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step(1);
    redirect_pc    = 32'h0000_0080;
    step(1);
    redirect_valid = 1'b0;
    step(14);
    check_vec("bb_pc0", at(got_pc, 0), 32'h0000_0080);
    check_vec("bb_pc1", at(got_pc, 1), 32'h0000_0084);
    check_vec("bb_data0", at(got_data, 0), 32'h0000_1080);

    // ---- reset mid-operation ----
    lat = 3;
    inst_ready = 1'b0;
    do_reset();
    step(5);
    @(negedge clk);
    check_vec("mr_busy_valid", 32'(inst_valid), 32'd1);
    step(1);
    reset = 1'b1;
    lat = 1;
    inst_ready = 1'b1;
    step(1);
    @(negedge clk);
    check_vec("mr_inst_valid", 32'(inst_valid), 32'd0);
    check_vec("mr_req_valid", 32'(req_valid), 32'd0);
    check_vec("mr_inst_pc", inst_pc, 32'h0);
    step(1);
    do_reset();
    @(negedge clk);
    check_vec("mr_restart_addr", req_addr, 32'h0);
    step(8);
    check_vec("mr_pc0", at(got_pc, 0), 32'h0);
    check_vec("mr_data0", at(got_data, 0), 32'h1000);
    check_vec("mr_latency", 32'(first_dl - first_hs), 32'(EXP_LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
